// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Command/result bundle of the sequential divider; the master issues
// operations and the slave (the divider) answers with a registered result.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               op_start;
  logic               op_clear;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] result;
  logic               op_done;
  logic               div_by_zero;

  modport master (
    output op_start, op_clear, dividend, divisor,
    input  result, op_done, div_by_zero
  );

  modport slave (
    input  op_start, op_clear, dividend, divisor,
    output result, op_done, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift {rem,quo} left, then subtract the
// divisor from the remainder when it fits and record the outcome in quo's LSB.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  // The shifted remainder needs one extra bit, since it can reach 2*divisor-1.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    trial    = shifted[WIDTH-1:0] - divisor;
    next_rem = fits ? trial : shifted[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one restoring step per clock, WIDTH steps per
// division, with a registered {remainder, quotient} result held in DONE.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          reset_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   step_cnt;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [2*WIDTH-1:0] result_q;
  logic               done_q;
  logic               dbz_q;
  logic               load;
  logic               zero_div;
  logic               finishing;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A zero divisor spends a single cycle in EXEC and then finishes without stepping.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    zero_div   = (divisor_q == '0);
    case (state)
      IDLE: begin
        if (!bus.op_clear && bus.op_start) begin
          next_state = EXEC;
          load       = 1'b1;
        end
      end
      EXEC: begin
        if (bus.op_clear)                              next_state = IDLE;
        else if (zero_div || step_cnt == LAST_STEP)    next_state = DONE;
      end
      DONE: begin
        if (bus.op_clear) begin
          next_state = IDLE;
        end else if (bus.op_start) begin
          next_state = EXEC;
          load       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    finishing = (state == EXEC) && (next_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      step_cnt  <= '0;
    end else if (load) begin
      divisor_q <= bus.divisor;
      quo_q     <= bus.dividend;
      rem_q     <= '0;
      step_cnt  <= '0;
    end else if (state == EXEC && !zero_div) begin
      rem_q    <= step_rem;
      quo_q    <= step_quo;
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  // Outputs are loaded only on entry to DONE and held there; anywhere else they read zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (finishing) begin
      result_q <= zero_div ? {quo_q, {WIDTH{1'b1}}} : {step_rem, step_quo};
      done_q   <= 1'b1;
      dbz_q    <= zero_div;
    end else if (next_state != DONE) begin
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end
  end

  assign bus.result      = result_q;
  assign bus.op_done     = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results from a
// plain-arithmetic model, an independent monitor pops them on op_done.
module tb_seq_divider;
  import seq_divider_pkg::*;

  typedef struct {
    logic [63:0] result;
    bit          dbz;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        reset_n;
  int unsigned cycle;
  int unsigned checks;
  int unsigned errors;
  bit          monitorOn;
  bit          prevDone;
  logic [63:0] heldResult;
  bit          heldDbz;
  exp_t        expQ[$];
  exp_t        mon;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [63:0] r, output bit z, output int unsigned lat);
    if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
      z = 1'b1;
      lat = 1;
    end else begin
      r = {a % b, a / b};
      z = 1'b0;
      lat = 32;
    end
  endfunction

  // Called at a negedge; the start is sampled by the following posedge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit wantDone,
                               output int unsigned lat);
    exp_t e;
    refModel(a, b, e.result, e.dbz, lat);
    e.due = cycle + 1 + lat;
    if (wantDone) expQ.push_back(e);
    bus.dividend = a;
    bus.divisor  = b;
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
  endtask

  task automatic waitDone(input int unsigned lat);
    int unsigned n = 0;
    while (bus.op_done !== 1'b1 && n < lat + 4) begin
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      bus.op_start = (n + 2 < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    bus.op_start = 1'b0;
    checkOutput("op_done_within_budget", {63'd0, bus.op_done}, 64'd1);
  endtask

  task automatic doClear();
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      if (bus.op_done && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_op_done", {63'd0, bus.op_done}, 64'd0);
        end else begin
          mon = expQ.pop_front();
          checkOutput("result", bus.result, mon.result);
          checkOutput("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, mon.dbz});
          checkOutput("latency", 64'(cycle), 64'(mon.due));
          heldResult = mon.result;
          heldDbz    = mon.dbz;
        end
      end else if (bus.op_done) begin
        checkOutput("hold_result", bus.result, heldResult);
        checkOutput("hold_dbz", {63'd0, bus.div_by_zero}, {63'd0, heldDbz});
      end else begin
        checkOutput("inactive_result_zero", bus.result, 64'd0);
        checkOutput("inactive_dbz_zero", {63'd0, bus.div_by_zero}, 64'd0);
      end
      prevDone = bus.op_done;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned lat;
    logic [31:0] a;
    logic [31:0] b;
    reset_n      = 1'b0;
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result", bus.result, 64'd0);
    checkOutput("reset_op_done", {63'd0, bus.op_done}, 64'd0);
    checkOutput("reset_state", 64'(dut.state), 64'(IDLE));
    monitorOn = 1'b1;
    reset_n   = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(32'd100, 32'd7, 1'b1, lat);          waitDone(lat); doClear();
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b1, lat);    waitDone(lat); doClear();
    applyStimulus(32'd5, 32'd9, 1'b1, lat);            waitDone(lat); doClear();
    applyStimulus(32'd123, 32'd0, 1'b1, lat);          waitDone(lat); doClear();

    $display("[TB] restart from DONE");
    applyStimulus(32'd100, 32'd7, 1'b1, lat);          waitDone(lat);
    repeat (3) @(negedge clk);
    applyStimulus(32'd81, 32'd9, 1'b1, lat);
    checkOutput("done_drops_on_restart", {63'd0, bus.op_done}, 64'd0);
    waitDone(lat); doClear();

    $display("[TB] abort with op_clear");
    applyStimulus(32'd1000, 32'd3, 1'b0, lat);
    repeat (9) @(negedge clk);
    doClear();
    checkOutput("abort_state_idle", 64'(dut.state), 64'(IDLE));
    repeat (40) begin
      @(negedge clk);
      checkOutput("abort_no_done", {63'd0, bus.op_done}, 64'd0);
    end

    $display("[TB] reset during EXEC");
    applyStimulus(32'd1000, 32'd3, 1'b0, lat);
    repeat (4) @(negedge clk);
    reset_n      = 1'b0;
    bus.op_start = 1'b1;
    bus.dividend = 32'd55;
    bus.divisor  = 32'd5;
    @(negedge clk);
    reset_n      = 1'b1;
    bus.op_start = 1'b0;
    checkOutput("mid_reset_state", 64'(dut.state), 64'(IDLE));
    checkOutput("mid_reset_result", bus.result, 64'd0);
    repeat (40) begin
      @(negedge clk);
      checkOutput("mid_reset_no_done", {63'd0, bus.op_done}, 64'd0);
    end
    applyStimulus(32'd100, 32'd7, 1'b1, lat);          waitDone(lat); doClear();

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = $urandom_range(1, 15);
        3:       b = a;
        default: b = $urandom;
      endcase
      applyStimulus(a, b, 1'b1, lat);
      waitDone(lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: doClear();
        1: begin
          bus.op_clear = 1'b1;
          applyStimulus($urandom, $urandom, 1'b0, lat);
          bus.op_clear = 1'b0;
          checkOutput("clear_beats_start", 64'(dut.state), 64'(IDLE));
        end
        default: ;
      endcase
    end
    doClear();
    repeat (3) @(negedge clk);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; result width is 2*WIDTH.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-004 Port: op_start  input  1  starts a division when sampled high.
REQ-005 Port: op_clear  input  1  aborts or acknowledges the current division and returns to IDLE.
REQ-006 Port: dividend  input  WIDTH  unsigned dividend, sampled with op_start.
REQ-007 Port: divisor  input  WIDTH  unsigned divisor, sampled with op_start.
REQ-008 Port: result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
REQ-009 Port: op_done  output  1  high while result is valid.
REQ-010 Port: div_by_zero  output  1  high with op_done when the sampled divisor was 0.

Function
REQ-011 FSM has exactly three states: IDLE, EXEC, DONE.
REQ-012 IDLE: op_start=1 and op_clear=0 latches dividend and divisor, clears the step counter and partial remainder, and moves to EXEC; the state is otherwise held.
REQ-013 EXEC: each cycle performs one restoring step. Shift {rem,quo} left by 1. Trial = rem - divisor. If trial >= 0, rem = trial and quo LSB = 1; otherwise quo LSB = 0.
REQ-014 EXEC: the step counter counts 0..WIDTH-1. The edge that completes step WIDTH-1 moves to DONE.
REQ-015 Latency: if op_start is sampled at edge k, op_done is high after edge k+WIDTH (32 cycles at the default width).
REQ-016 EXEC ignores op_start; operand inputs may change freely after the start edge.
REQ-017 If the divisor is 0, EXEC is bypassed. The next edge enters DONE with quotient all-ones, remainder = dividend and div_by_zero=1.
REQ-018 DONE drives result and op_done=1, and holds both stable until op_clear or op_start.
REQ-019 DONE: op_start=1 (op_clear=0) latches new operands and re-enters EXEC; op_done drops on that edge.
REQ-020 op_clear=1 in any state moves to IDLE on the next edge. It has priority over op_start and aborts EXEC without producing a result.
REQ-021 result=0, op_done=0 and div_by_zero=0 in IDLE and EXEC; partial values are never visible on result.
REQ-022 All outputs are registered; no combinational path exists from any input to any output.

Reset
REQ-023 reset_n=0 sampled on a clock edge forces IDLE, result=0, op_done=0, div_by_zero=0, counter=0 and internal operand registers=0.
REQ-024 reset_n has priority over op_clear and op_start. Reset mid-EXEC discards the operation; no op_done follows.

Structure
REQ-025 Shared package holds the state encoding (IDLE=2'b00, EXEC=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-026 One combinational sub-module, div_step, implements a single restoring step: inputs rem, quo and divisor; outputs next rem and next quo.
REQ-027 The counter is $clog2(WIDTH)+1 bits wide; there is no other arithmetic outside div_step.

Verification
REQ-028 dividend=100, divisor=7, op_start for 1 cycle -> after 32 cycles op_done=1 and result = {32'd2, 32'd14}, div_by_zero=0.
REQ-029 dividend=32'hFFFFFFFF, divisor=1 -> result = {32'd0, 32'hFFFFFFFF}; dividend=5, divisor=9 -> result = {32'd5, 32'd0}.
REQ-030 divisor=0, dividend=123 -> op_done after 1 cycle, result = {32'd123, 32'hFFFFFFFF}, div_by_zero=1.
REQ-031 op_clear at cycle 10 of EXEC -> IDLE next edge, result=0, op_done stays 0 for 40 further cycles.
REQ-032 reset_n=0 at cycle 5 of EXEC together with op_start=1 -> all outputs 0 and state IDLE; a subsequent 100/7 completes correctly.
REQ-033 In DONE of 100/7, apply op_start with 81/9 -> op_done low next edge, then high 32 cycles later with result = {32'd0, 32'd9}.
